pc_hazard_ctrl: RTL and testbench

Pipeline control block that sequences the PC unit in the 5-stage MIPS pipeline. It detects load-use and multiply/divide-busy hazards and drives the PC unit's stall input. It resolves branch and jump redirects from the ID stage into the PC unit's PcSel and j inputs. It generates the IF/ID flush and ID/EX bubble controls, and keeps a saturating stall-cycle performance counter.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/hazard_cmp.sv | 26 ++
 rtl/pc_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pc_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types and constants for the PC hazard/redirect control slice.
//   md_state_e     : mult/div busy tracker states (RUN, MD_BUSY)
//   REG_ZERO       : MIPS $zero register index; never a hazard source
//   MD_LATENCY_DEF : default HI/LO unavailability window after mult/div issue
//   MD_CNT_W       : width of the busy down-counter (covers latency 1..15)
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 5;
  localparam int         MD_CNT_W       = 4;

endpackage : pc_ctrl_pkg

// File: rtl/hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Combinational source-operand match of the ID instruction against the
// destination register of the EX instruction.
// Ports:
//   IdRs, IdRt         : source register fields of the ID instruction
//   IdUsesRs, IdUsesRt : qualifiers; an unused field never matches
//   ExRd               : destination register of the EX instruction
//   match              : 1 when a used source equals a non-zero ExRd
// -----------------------------------------------------------------------------
module hazard_cmp
  import pc_ctrl_pkg::*;
(
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       IdUsesRs,
  input  logic       IdUsesRt,
  input  logic [4:0] ExRd,
  output logic       match
);

  // Writes to $zero are discarded, so they can never create a dependency.
  assign match = (ExRd != REG_ZERO) &&
                 ((IdUsesRs && (IdRs == ExRd)) || (IdUsesRt && (IdRt == ExRd)));

endmodule : hazard_cmp

// File: rtl/pc_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pc_hazard_ctrl
// Sequences the PC unit of the 5-stage MIPS pipeline: detects load-use and
// mult/div-busy hazards, resolves branch/jump redirects from ID, drives the
// IF/ID flush and ID/EX bubble, and counts stall cycles (saturating).
//
// Optional build macro: BRANCH_HAZARD_EN
//   defined   : a branch in ID whose operand is written by the EX instruction
//               stalls one cycle (ExRegWrite is used)
//   undefined : no branch hazard; ExRegWrite is ignored and branch operand
//               forwarding is left to the datapath
//
// Parameters:
//   MD_LATENCY : cycles HI/LO stays unavailable after a mult/div issues (1..15)
//   CNT_W      : width of StallCycles
// Ports:
//   Clk, ReSet_n        : clock (rising edge), async active-low reset
//   IdRs/IdRt/IdUses*   : ID source operands and their use qualifiers
//   IdUsesMd            : ID reads HI/LO or issues mult/div
//   IdBranch/IdBranchTaken/IdJump : ID control-flow info
//   ExMemRead/ExRegWrite/ExRd     : EX instruction info
//   MdStart             : mult/div enters EX this cycle
//   stall, PcSel, j     : PC unit controls (combinational)
//   IfIdFlush, IdExBubble : pipeline register controls (combinational)
//   StallCycles         : saturating count of stall cycles (registered)
// -----------------------------------------------------------------------------
module pc_hazard_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             ReSet_n,
  input  logic [4:0]       IdRs,
  input  logic [4:0]       IdRt,
  input  logic             IdUsesRs,
  input  logic             IdUsesRt,
  input  logic             IdUsesMd,
  input  logic             IdBranch,
  input  logic             IdBranchTaken,
  input  logic             IdJump,
  input  logic             ExMemRead,
  input  logic             ExRegWrite,
  input  logic [4:0]       ExRd,
  input  logic             MdStart,
  output logic             stall,
  output logic             PcSel,
  output logic             j,
  output logic             IfIdFlush,
  output logic             IdExBubble,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic match;
  logic load_use;
  logic md_haz;
  logic br_haz;
  logic hazard;

  hazard_cmp u_cmp (
    .IdRs     (IdRs),
    .IdRt     (IdRt),
    .IdUsesRs (IdUsesRs),
    .IdUsesRt (IdUsesRt),
    .ExRd     (ExRd),
    .match    (match)
  );

  assign load_use = ExMemRead && match;
  assign md_haz   = (state_q == MD_BUSY) && IdUsesMd;

`ifdef BRANCH_HAZARD_EN
  // Loads also set ExRegWrite, so this subsumes load-use for branches.
  assign br_haz = IdBranch && ExRegWrite && match;
`else
  logic unused_ex_reg_write;
  assign unused_ex_reg_write = ExRegWrite;
  assign br_haz = 1'b0;
`endif

  assign hazard = load_use || md_haz || br_haz;

  // Outputs are gated by ReSet_n so the PC unit sees no stall or redirect
  // while reset is held, independent of whatever the ID/EX inputs carry.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    stall      = 1'b0;
    IdExBubble = 1'b0;
    PcSel      = 1'b0;
    j          = 1'b0;
    IfIdFlush  = 1'b0;
    if (ReSet_n) begin
      stall      = hazard;
      IdExBubble = hazard;
      // A stalled redirect is dropped; the instruction stays in ID and is
      // re-evaluated once the hazard clears. Jump beats branch.
      if (!hazard) begin
        if (IdJump) begin
          j = 1'b1;
        end else if (IdBranch && IdBranchTaken) begin
          PcSel = 1'b1;
        end
      end
      IfIdFlush = PcSel || j;
    end
  end

  // Mult/div busy tracker. A new MdStart always restarts the window, so the
  // hazard lasts exactly MD_LATENCY cycles after the most recent issue.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      RUN: begin
        if (MdStart) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_RELOAD;
        end
      end
      MD_BUSY: begin
        if (MdStart) begin
          md_cnt_d = MD_RELOAD;
        end else if (md_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge ReSet_n) begin
    if (!ReSet_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_ff @(posedge Clk or negedge ReSet_n) begin
    if (!ReSet_n) begin
      StallCycles <= '0;
    end else if (stall && (StallCycles != '1)) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule : pc_hazard_ctrl

// File: tb/tb_pc_hazard_ctrl.sv
module tb_pc_hazard_ctrl;

  localparam int LAT = 5;
  localparam int CW  = 6;

  logic          Clk = 1'b0;
  logic          ReSet_n = 1'b0;
  logic [4:0]    IdRs, IdRt, ExRd;
  logic          IdUsesRs, IdUsesRt, IdUsesMd, IdBranch, IdBranchTaken, IdJump;
  logic          ExMemRead, ExRegWrite, MdStart;
  logic          stall, PcSel, j, IfIdFlush, IdExBubble;
  logic [CW-1:0] StallCycles;

  pc_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .Clk           (Clk),
    .ReSet_n       (ReSet_n),
    .IdRs          (IdRs),
    .IdRt          (IdRt),
    .IdUsesRs      (IdUsesRs),
    .IdUsesRt      (IdUsesRt),
    .IdUsesMd      (IdUsesMd),
    .IdBranch      (IdBranch),
    .IdBranchTaken (IdBranchTaken),
    .IdJump        (IdJump),
    .ExMemRead     (ExMemRead),
    .ExRegWrite    (ExRegWrite),
    .ExRd          (ExRd),
    .MdStart       (MdStart),
    .stall         (stall),
    .PcSel         (PcSel),
    .j             (j),
    .IfIdFlush     (IfIdFlush),
    .IdExBubble    (IdExBubble),
    .StallCycles   (StallCycles)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: cycle index, cycle of the latest mult/div issue,
  // and the expected stall count.
  int            cyc     = 0;
  int            last_md = -1000;
  logic [CW-1:0] m_cnt   = '0;

  // Expected {stall, IdExBubble, PcSel, j, IfIdFlush} for the current inputs.
  function automatic logic [4:0] model_comb();
    bit hit, st;
    hit = (ExRd != 5'd0) &&
          ((IdUsesRs && IdRs == ExRd) || (IdUsesRt && IdRt == ExRd));
    st  = (ExMemRead && hit) ||
          (IdUsesMd && (cyc - last_md >= 1) && (cyc - last_md <= LAT));
`ifdef BRANCH_HAZARD_EN
    st = st || (IdBranch && ExRegWrite && hit);
`endif
    if (!ReSet_n)                  return 5'b00000;
    if (st)                        return 5'b11000;
    if (IdJump)                    return 5'b00011;
    if (IdBranch && IdBranchTaken) return 5'b00101;
    return 5'b00000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    IdRs = 5'd0; IdRt = 5'd0; ExRd = 5'd0;
    IdUsesRs = 1'b0; IdUsesRt = 1'b0; IdUsesMd = 1'b0;
    IdBranch = 1'b0; IdBranchTaken = 1'b0; IdJump = 1'b0;
    ExMemRead = 1'b0; ExRegWrite = 1'b0; MdStart = 1'b0;
  endtask

  task automatic nx();
    @(negedge Clk);
  endtask

  // Check the combinational outputs, clock once, advance the model and
  // check the counter. Inputs stay stable until the caller's next nx().
  task automatic step(input string tag);
    logic [4:0] e;
    #1;
    e = model_comb();
    check({tag, "_comb"}, 32'({stall, IdExBubble, PcSel, j, IfIdFlush}), 32'(e));
    @(posedge Clk);
    if (e[4] && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    if (MdStart) last_md = cyc;
    cyc++;
    #1;
    check({tag, "_cnt"}, 32'(StallCycles), 32'(m_cnt));
  endtask

  initial begin
    logic [CW-1:0] cnt0;
    clear_in();
    // Reset held with a hazardous input pattern: everything must read 0.
    ExMemRead = 1'b1; ExRd = 5'd8; IdRs = 5'd8; IdUsesRs = 1'b1; IdJump = 1'b1;
    #12;
    check("rst_outs", 32'({stall, IdExBubble, PcSel, j, IfIdFlush}), 32'd0);
    check("rst_cnt", 32'(StallCycles), 32'd0);
    nx(); clear_in(); ReSet_n = 1'b1;

    // Async reset mid-busy (md_cnt=3).
    nx(); MdStart = 1'b1; step("md_issue");
    nx(); MdStart = 1'b0; IdUsesMd = 1'b1; step("md_busy1");
    nx();
    #1 check("md_busy2", 32'(stall), 32'd1);
    #1 ReSet_n = 1'b0;
    #1 check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_cnt", 32'(StallCycles), 32'd0);
    last_md = -1000; m_cnt = '0;
    nx(); ReSet_n = 1'b1; IdUsesMd = 1'b1;
    step("post_rst");
    check("post_rst_stall", 32'(stall), 32'd0);

    // Load-use.
    nx(); clear_in(); ExMemRead = 1'b1; ExRd = 5'd8; IdRs = 5'd8; IdUsesRs = 1'b1;
    cnt0 = StallCycles;
    step("lu");
    check("lu_stall", 32'({stall, IdExBubble}), 32'b11);
    check("lu_cnt_inc", 32'(StallCycles), 32'(cnt0 + 1'b1));
    nx(); ExRd = 5'd0; IdRs = 5'd0;
    step("lu_zero");
    check("lu_zero_stall", 32'(stall), 32'd0);

    // Taken branch during a load-use stall, then after it clears.
    nx(); ExRd = 5'd8; IdRs = 5'd8; IdBranch = 1'b1; IdBranchTaken = 1'b1;
    step("br_stalled");
    check("br_stalled_redir", 32'({PcSel, IfIdFlush}), 32'b00);
    nx(); ExMemRead = 1'b0;
    step("br_taken");
    check("br_taken_redir", 32'({PcSel, IfIdFlush}), 32'b11);

    // Jump beats branch.
    nx(); clear_in(); IdJump = 1'b1; IdBranch = 1'b1; IdBranchTaken = 1'b1;
    step("jmp_prio");
    check("jmp_prio_out", 32'({j, PcSel, IfIdFlush}), 32'b101);

    // MD window: issue at cycle 0, stall on cycles 1..5.
    for (int k = 0; k <= 6; k++) begin
      nx(); clear_in(); IdUsesMd = 1'b1; MdStart = (k == 0);
      #1 check("md_win", 32'(stall), 32'((k >= 1) && (k <= 5)));
      step("md_win");
    end
    // Re-issue at cycle 3 extends the window through cycle 8.
    for (int k = 0; k <= 9; k++) begin
      nx(); clear_in(); IdUsesMd = 1'b1; MdStart = (k == 0) || (k == 3);
      #1 check("md_ext", 32'(stall), 32'((k >= 1) && (k <= 8)));
      step("md_ext");
    end

    // Optional branch hazard.
    nx(); clear_in(); IdBranch = 1'b1; ExRegWrite = 1'b1; ExRd = 5'd9;
    IdRt = 5'd9; IdUsesRt = 1'b1;
`ifdef BRANCH_HAZARD_EN
    #1 check("br_haz", 32'(stall), 32'd1);
`else
    #1 check("br_haz", 32'(stall), 32'd0);
`endif
    step("br_haz");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      nx();
      IdRs          = 5'($urandom_range(0, 3));
      IdRt          = 5'($urandom_range(0, 3));
      ExRd          = 5'($urandom_range(0, 3));
      IdUsesRs      = 1'($urandom_range(0, 1));
      IdUsesRt      = 1'($urandom_range(0, 1));
      IdUsesMd      = 1'($urandom_range(0, 1));
      IdBranch      = 1'($urandom_range(0, 1));
      IdBranchTaken = 1'($urandom_range(0, 1));
      IdJump        = ($urandom_range(0, 3) == 0);
      ExMemRead     = 1'($urandom_range(0, 1));
      ExRegWrite    = 1'($urandom_range(0, 1));
      MdStart       = ($urandom_range(0, 11) == 0);
      step("rand");
    end

    // Saturation: long load-use run drives the counter to all-ones.
    nx(); clear_in(); ExMemRead = 1'b1; ExRd = 5'd3; IdRt = 5'd3; IdUsesRt = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step("sat");
      nx();
    end
    step("sat_hold");
    check("sat_value", 32'(StallCycles), 32'((1 << CW) - 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_hazard_ctrl
